// File: rtl/mmio_bus_initiator.sv
// Command-driven initiator for the MMIO slot bus: write, read and masked-poll commands
// on a valid/ready port, single-cycle bus accesses, one response per command.
module mmio_bus_initiator #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = 32,
  parameter int POLL_MAX   = 1024,
  parameter int POLL_GAP   = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [1:0]            cmd_op,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  input  logic [DATA_WIDTH-1:0] cmd_mask,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  rsp_timeout,
  output logic                  rsp_err,
  output logic                  busy,
  output logic                  cs,
  output logic                  read,
  output logic                  write,
  output logic [ADDR_WIDTH-1:0] reg_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic [DATA_WIDTH-1:0] rd_data,
  output logic [1:0]            o_dbg_state
);
  // Handshakes: a command transfers on a clock edge where cmd_valid && cmd_ready;
  // a response transfers on an edge where rsp_valid && rsp_ready. Producers hold
  // valid and payload stable until the transfer edge.

  localparam int CNT_W = $clog2(POLL_MAX + 1);
  localparam int GAP_W = $clog2(POLL_GAP + 1);
  localparam logic [CNT_W-1:0] POLL_MAX_C = CNT_W'(POLL_MAX);
  localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(POLL_GAP - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_GAP    = 2'd2;
  localparam logic [1:0] ST_RESP   = 2'd3;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_READ  = 2'b01;
  localparam logic [1:0] OP_POLL  = 2'b10;
  localparam logic [1:0] OP_ILL   = 2'b11;

  logic [1:0]            r_state;
  logic [1:0]            r_op;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [DATA_WIDTH-1:0] r_data;
  logic [DATA_WIDTH-1:0] r_mask;
  logic [CNT_W-1:0]      r_poll_cnt;
  logic [GAP_W-1:0]      r_gap_cnt;
  logic                  r_cs;
  logic                  r_read;
  logic                  r_write;
  logic [ADDR_WIDTH-1:0] r_reg_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic                  r_rsp_valid;
  logic [DATA_WIDTH-1:0] r_rsp_data;
  logic                  r_rsp_timeout;
  logic                  r_rsp_err;

  logic                  w_handshake;
  logic                  w_match;
  logic [CNT_W-1:0]      w_cnt_inc;
  logic                  w_poll_done;

  assign cmd_ready   = reset_n && (r_state == ST_IDLE);
  assign busy        = (r_state != ST_IDLE);
  assign w_handshake = cmd_valid && cmd_ready;
  assign w_match     = ((rd_data ^ r_data) & r_mask) == '0;
  assign w_cnt_inc   = (r_poll_cnt == POLL_MAX_C) ? r_poll_cnt : r_poll_cnt + CNT_W'(1);
  assign w_poll_done = (w_cnt_inc == POLL_MAX_C);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= ST_IDLE;
      r_op          <= OP_WRITE;
      r_addr        <= '0;
      r_data        <= '0;
      r_mask        <= '0;
      r_poll_cnt    <= '0;
      r_gap_cnt     <= '0;
      r_cs          <= 1'b0;
      r_read        <= 1'b0;
      r_write       <= 1'b0;
      r_reg_addr    <= '0;
      r_wr_data     <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_data    <= '0;
      r_rsp_timeout <= 1'b0;
      r_rsp_err     <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_handshake) begin
            r_op       <= cmd_op;
            r_addr     <= cmd_addr;
            r_data     <= cmd_data;
            r_mask     <= cmd_mask;
            r_poll_cnt <= '0;
            if (cmd_op == OP_ILL) begin
              r_state     <= ST_RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_data  <= '0;
            end else begin
              // Strobes are launched here so they are visible during the ACCESS cycle.
              r_state    <= ST_ACCESS;
              r_cs       <= 1'b1;
              r_read     <= (cmd_op != OP_WRITE);
              r_write    <= (cmd_op == OP_WRITE);
              r_reg_addr <= cmd_addr;
              r_wr_data  <= (cmd_op == OP_WRITE) ? cmd_data : '0;
            end
          end
        end
        ST_ACCESS: begin
          r_cs       <= 1'b0;
          r_read     <= 1'b0;
          r_write    <= 1'b0;
          r_wr_data  <= '0;
          r_rsp_data <= (r_op == OP_WRITE) ? '0 : rd_data;
          if (r_op != OP_POLL || w_match) begin
            r_state     <= ST_RESP;
            r_rsp_valid <= 1'b1;
          end else begin
            r_poll_cnt <= w_cnt_inc;
            if (w_poll_done) begin
              r_state       <= ST_RESP;
              r_rsp_valid   <= 1'b1;
              r_rsp_timeout <= 1'b1;
            end else begin
              r_state   <= ST_GAP;
              r_gap_cnt <= '0;
            end
          end
        end
        ST_GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            r_state <= ST_ACCESS;
            r_cs    <= 1'b1;
            r_read  <= 1'b1;
          end else begin
            r_gap_cnt <= r_gap_cnt + GAP_W'(1);
          end
        end
        default: begin
          if (rsp_ready) begin
            r_state       <= ST_IDLE;
            r_rsp_valid   <= 1'b0;
            r_rsp_data    <= '0;
            r_rsp_timeout <= 1'b0;
            r_rsp_err     <= 1'b0;
          end
        end
      endcase
    end
  end

  assign cs          = r_cs;
  assign read        = r_read;
  assign write       = r_write;
  assign reg_addr    = r_reg_addr;
  assign wr_data     = r_wr_data;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_data    = r_rsp_data;
  assign rsp_timeout = r_rsp_timeout;
  assign rsp_err     = r_rsp_err;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_mmio_bus_initiator.sv
// Bench for mmio_bus_initiator: directed vector table, rising-status poll, mid-poll reset,
// then random commands checked against a register-file reference model.
module tb_mmio_bus_initiator;
  localparam int AW = 5;
  localparam int DW = 32;
  localparam int PM = 4;
  localparam int PG = 3;

  logic          clk = 1'b0;
  logic          reset_n = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = 2'b00;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_data = '0;
  logic [DW-1:0] cmd_mask = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_data;
  logic          rsp_timeout;
  logic          rsp_err;
  logic          busy;
  logic          cs;
  logic          read;
  logic          write;
  logic [AW-1:0] reg_addr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] rd_data;
  logic [1:0]    dbg_state;

  int total_cnt = 0;
  int pass_cnt  = 0;

  // clock / reset
  always #5 clk = ~clk;

  mmio_bus_initiator #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .POLL_MAX(PM), .POLL_GAP(PG)) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op), .cmd_addr(cmd_addr),
    .cmd_data(cmd_data), .cmd_mask(cmd_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_timeout(rsp_timeout), .rsp_err(rsp_err), .busy(busy),
    .cs(cs), .read(read), .write(write), .reg_addr(reg_addr), .wr_data(wr_data),
    .rd_data(rd_data), .o_dbg_state(dbg_state)
  );

  // slave register file and bus monitor
  logic [DW-1:0] regs [32];
  logic          seeded = 1'b0;
  logic          ovr_en = 1'b0;
  int            ovr_reads = 0;
  int            cyc = 0, rd_cnt = 0, wr_cnt = 0;
  int            rw_both = 0, cs_bad = 0, b2b = 0;
  logic          prev_cs = 1'b0;
  logic [AW-1:0] last_acc_addr = '0;
  logic [DW-1:0] last_wr_data = '0;
  int            read_times[$];

  function automatic logic [DW-1:0] init_val(int i);
    return (i == 3) ? 32'hDEADBEEF : (32'hC0DE_0000 | DW'(i));
  endfunction

  // Status override: bit 3 of register 0 rises on the third read while ovr_en is set.
  assign rd_data = (ovr_en && reg_addr == '0) ? (regs[0] | ((ovr_reads >= 2) ? 32'h8 : 32'h0))
                                              : regs[reg_addr];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!seeded) begin
      for (int i = 0; i < 32; i++) regs[i] <= init_val(i);
      seeded <= 1'b1;
    end
    prev_cs <= cs;
    if (cs && prev_cs) b2b <= b2b + 1;
    if (read && write) rw_both <= rw_both + 1;
    if (cs != (read ^ write)) cs_bad <= cs_bad + 1;
    if (cs) last_acc_addr <= reg_addr;
    if (cs && write) begin
      regs[reg_addr] <= wr_data;
      wr_cnt         <= wr_cnt + 1;
      last_wr_data   <= wr_data;
    end
    if (cs && read) begin
      rd_cnt <= rd_cnt + 1;
      read_times.push_back(cyc);
      if (ovr_en && reg_addr == '0) ovr_reads <= ovr_reads + 1;
    end
    if (!ovr_en) ovr_reads <= 0;
  end

  // scoreboard
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_regs [32];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // driver: one command, bounded wait for its response, optional back-pressure
  task automatic run_cmd(input logic [1:0] op, input logic [AW-1:0] addr, input logic [DW-1:0] data,
                         input logic [DW-1:0] mask, input int hold, input logic [DW-1:0] e_data,
                         input logic e_err, input logic e_to, input int e_lat, input int e_reads,
                         input int e_writes, input string tag);
    int rd0, wr0, lat;
    logic seen, er, to, stab, rdylow;
    logic [DW-1:0] d;
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    @(negedge clk);
    for (int k = 0; k < 50 && !cmd_ready; k++) @(negedge clk);
    check({tag, ".cmd_ready"}, cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data; cmd_mask = mask;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_data = $urandom; cmd_mask = $urandom;
    seen = 1'b0;
    lat = 0;
    while (!seen && lat < 200) begin
      @(negedge clk);
      lat++;
      seen = rsp_valid;
    end
    check({tag, ".rsp_seen"}, seen, 1);
    check({tag, ".latency"}, lat, e_lat);
    d = rsp_data; er = rsp_err; to = rsp_timeout;
    check({tag, ".rsp_data"}, d, e_data);
    check({tag, ".rsp_err"}, er, e_err);
    check({tag, ".rsp_timeout"}, to, e_to);
    stab = 1'b1;
    rdylow = 1'b1;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      if ({rsp_valid, rsp_data, rsp_err, rsp_timeout} !== {1'b1, d, er, to}) stab = 1'b0;
      if (cmd_ready || !busy) rdylow = 1'b0;
    end
    if (hold > 0) begin
      check({tag, ".rsp_stable"}, stab, 1);
      check({tag, ".ready_low"}, rdylow, 1);
    end
    rsp_ready = 1'b1;
    @(posedge clk);
    #1 rsp_ready = 1'b0;
    @(negedge clk);
    check({tag, ".post"}, {rsp_valid, rsp_err, rsp_timeout, cmd_ready, busy}, 5'b00010);
    check({tag, ".reads"}, rd_cnt - rd0, e_reads);
    check({tag, ".writes"}, wr_cnt - wr0, e_writes);
    if (e_writes > 0) check({tag, ".wr_data"}, last_wr_data, data);
    if (e_reads + e_writes > 0) check({tag, ".bus_addr"}, last_acc_addr, addr);
  endtask

  typedef struct {
    logic [1:0]    op;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] mask;
    int            hold;
    logic [DW-1:0] e_data;
    logic          e_err;
    logic          e_to;
    int            e_lat;
    int            e_reads;
    int            e_writes;
  } vec_t;

  vec_t tbl[9];

  initial begin
    int n0, rd0, seen_rsp, e_reads, e_lat;
    logic [1:0] op;
    logic [AW-1:0] addr;
    logic [DW-1:0] data, mask, e_data;
    logic e_to, e_err;

    tbl[0] = '{2'b00, 5'd0,  32'h1,         32'h0,         0, 32'h0,         0, 0, 2, 0, 1};
    tbl[1] = '{2'b01, 5'd3,  32'h0,         32'h0,         5, 32'hDEADBEEF,  0, 0, 2, 1, 0};
    tbl[2] = '{2'b01, 5'd0,  32'h0,         32'h0,         1, 32'h1,         0, 0, 2, 1, 0};
    tbl[3] = '{2'b11, 5'd7,  32'h1234,      32'hFFFF,      2, 32'h0,         1, 0, 1, 0, 0};
    tbl[4] = '{2'b10, 5'd3,  32'h55,        32'h0,         0, 32'hDEADBEEF,  0, 0, 2, 1, 0};
    tbl[5] = '{2'b10, 5'd3,  32'hD000_0000, 32'hF000_0000, 0, 32'hDEADBEEF,  0, 0, 2, 1, 0};
    tbl[6] = '{2'b10, 5'd3,  32'h0,         32'h1,         3, 32'hDEADBEEF,  0, 1, 2 + (PM-1)*(PG+1), PM, 0};
    tbl[7] = '{2'b00, 5'd31, 32'hA5A5_A5A5, 32'h0,         0, 32'h0,         0, 0, 2, 0, 1};
    tbl[8] = '{2'b01, 5'd31, 32'h0,         32'h0,         0, 32'hA5A5_A5A5, 0, 0, 2, 1, 0};

    #1 reset_n = 1'b0;
    #2;
    check("reset.cmd_ready", cmd_ready, 0);
    check("reset.outputs", {cs, read, write, rsp_valid, rsp_err, rsp_timeout, busy}, 7'b0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("reset.idle", {cmd_ready, busy, rsp_valid, reg_addr, wr_data, rsp_data}, {1'b1, 1'b0, 1'b0, 5'd0, 32'd0, 32'd0});

    for (int i = 0; i < 32; i++) exp_regs[i] = init_val(i);
    for (int i = 0; i < 9; i++) begin
      run_cmd(tbl[i].op, tbl[i].addr, tbl[i].data, tbl[i].mask, tbl[i].hold, tbl[i].e_data,
              tbl[i].e_err, tbl[i].e_to, tbl[i].e_lat, tbl[i].e_reads, tbl[i].e_writes,
              $sformatf("vec%0d", i));
      if (tbl[i].op == 2'b00) exp_regs[tbl[i].addr] = tbl[i].data;
    end

    // Poll waiting on a status bit that rises on the third read.
    ovr_en = 1'b1;
    n0 = read_times.size();
    run_cmd(2'b10, 5'd0, 32'h8, 32'h8, 0, exp_regs[0] | 32'h8, 0, 0, 2 + 2*(PG+1), 3, 0, "poll_rise");
    ovr_en = 1'b0;
    if (read_times.size() >= n0 + 3) begin
      check("poll_rise.gap1", read_times[n0+1] - read_times[n0], PG + 1);
      check("poll_rise.gap2", read_times[n0+2] - read_times[n0+1], PG + 1);
    end else begin
      check("poll_rise.read_times", read_times.size() - n0, 3);
    end

    // Reset asserted while a poll sits in its gap.
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = 2'b10; cmd_addr = 5'd5; cmd_data = 32'h0; cmd_mask = 32'h1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    @(posedge clk);
    #3;
    check("midrst.pre", {busy, cs, reg_addr}, {1'b1, 1'b0, 5'd5});
    reset_n = 1'b0;
    #1;
    check("midrst.strobes", {cs, read, write}, 3'b0);
    check("midrst.rsp", {rsp_valid, rsp_err, rsp_timeout, busy, cmd_ready}, 5'b0);
    check("midrst.bus", {reg_addr, wr_data, rsp_data}, 69'b0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    rd0 = rd_cnt;
    seen_rsp = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (rsp_valid) seen_rsp++;
    end
    check("midrst.no_rsp", seen_rsp, 0);
    check("midrst.no_reads", rd_cnt - rd0, 0);
    run_cmd(2'b01, 5'd5, 32'h0, 32'h0, 0, exp_regs[5], 0, 0, 2, 1, 0, "after_rst");

    // Random commands against the register-file model.
    for (int i = 0; i < 40; i++) begin
      op   = 2'($urandom_range(0, 3));
      addr = AW'($urandom_range(0, 31));
      data = $urandom;
      mask = $urandom;
      case ($urandom_range(0, 2))
        0: mask = '0;
        1: data = (exp_regs[addr] & mask) | (data & ~mask);
        default: ;
      endcase
      e_err = 1'b0; e_to = 1'b0; e_reads = 0; e_lat = 2; e_data = '0;
      case (op)
        2'b00: exp_regs[addr] = data;
        2'b01: begin e_data = exp_regs[addr]; e_reads = 1; end
        2'b10: begin
          e_data  = exp_regs[addr];
          e_reads = (((exp_regs[addr] ^ data) & mask) == '0) ? 1 : PM;
          e_to    = (e_reads == PM) && (((exp_regs[addr] ^ data) & mask) != '0);
          e_lat   = 2 + (e_reads - 1) * (PG + 1);
        end
        default: begin e_err = 1'b1; e_lat = 1; end
      endcase
      exp_q.push_back(e_data);
      run_cmd(op, addr, data, mask, $urandom_range(0, 2), exp_q.pop_front(), e_err, e_to, e_lat,
              e_reads, (op == 2'b00) ? 1 : 0, $sformatf("rnd%0d", i));
    end

    check("bus.read_and_write", rw_both, 0);
    check("bus.cs_strobe", cs_bad, 0);
    check("bus.back_to_back", b2b, 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/mmio_bus_initiator.md
Name: mmio_bus_initiator

Overview:
Command-driven initiator for the team's MMIO slot bus: cs/read/write strobes, 5-bit reg_addr, 32-bit wr_data and rd_data. Lets a hardware sequencer (or the testbench) drive Timer_Core and sibling cores without a processor. It accepts write, read and poll commands on a valid/ready port, issues single-cycle bus accesses and returns one response per command. Poll mode re-reads a register until a masked match, e.g. waiting on a timer status bit.

Parameters:
ADDR_WIDTH, 5, width of reg_addr and cmd_addr
DATA_WIDTH, 32, width of wr_data, rd_data, cmd_data, cmd_mask and rsp_data
POLL_MAX, 1024, maximum bus reads per poll command before timeout; must be at least 1
POLL_GAP, 4, idle cycles between successive poll reads; must be at least 1

Ports:
clk  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command offered
cmd_ready  out  1  high only in IDLE
cmd_op  in  2  00 write, 01 read, 10 poll, 11 illegal
cmd_addr  in  ADDR_WIDTH  target register
cmd_data  in  DATA_WIDTH  write data (write) or match value (poll)
cmd_mask  in  DATA_WIDTH  poll compare mask; ignored otherwise
rsp_valid  out  1  response available
rsp_ready  in  1  response consumed
rsp_data  out  DATA_WIDTH  read or last polled data; 0 for write and illegal
rsp_timeout  out  1  poll exhausted POLL_MAX reads
rsp_err  out  1  illegal op
busy  out  1  high whenever state is not IDLE
cs  out  1  bus chip select
read  out  1  bus read strobe
write  out  1  bus write strobe
reg_addr  out  ADDR_WIDTH  bus register address
wr_data  out  DATA_WIDTH  bus write data
rd_data  in  DATA_WIDTH  bus read data; slave drives it combinationally from reg_addr

Behaviour:
- Reset, asynchronous: state IDLE. cs, read, write, reg_addr, wr_data, rsp_valid, rsp_data, rsp_timeout, rsp_err and busy all 0. cmd_ready is 1 once reset_n is high. Reset mid-command drops the strobes immediately, discards the command and emits no response.
- All bus outputs and response outputs are registered. cmd_ready is a decode of state IDLE.
- States: IDLE, ACCESS, GAP, RESP.
- IDLE: a handshake (cmd_valid && cmd_ready) in cycle T latches op, addr, data and mask, and clears the poll counter.
  - Op 11 goes directly to RESP with rsp_err=1. There is no bus activity.
  - Any other op goes to ACCESS.
- ACCESS: lasts exactly one cycle (T+1 for the first access).
  - cs=1 in every case.
  - Write: write=1, wr_data=latched data.
  - Read or poll: read=1, wr_data=0.
  - reg_addr=latched addr. reg_addr holds its value after the access until the next ACCESS.
  - rd_data is sampled at the end of the ACCESS cycle.
- After ACCESS:
  - Write goes to RESP with rsp_data=0.
  - Read goes to RESP with rsp_data=sampled rd_data.
  - Poll, if (rd_data & mask)==(data & mask): goes to RESP with the sampled data and rsp_timeout=0.
  - Poll, otherwise: increment the poll counter. If the counter reaches POLL_MAX, go to RESP with the last sampled data and rsp_timeout=1. If not, go to GAP.
- GAP: stays exactly POLL_GAP cycles with all strobes 0, then returns to ACCESS.
- RESP: rsp_valid=1 with stable data and flags until the cycle where rsp_valid && rsp_ready. The next cycle is IDLE, with rsp_valid=0 and the flags cleared.
- Latency: the first response is visible in cycle T+2 for read and write, and in T+1 for an illegal op.
- Back-to-back commands: there is at least one strobe-free cycle between bus accesses, and read and write are never asserted together.
- Only one command is outstanding at a time. cmd_valid while busy is ignored; the offering side must hold it.
- Poll with mask=0 matches on the first read, so exactly one bus read occurs.
- The poll counter is $clog2(POLL_MAX+1) bits wide and saturates at POLL_MAX.

Test Plan:
- After reset release: write op, addr 0, data 0x1, rsp_ready=1 -> cs=write=1 for exactly one cycle with reg_addr=0 and wr_data=0x1; rsp_valid the next cycle with rsp_data=0, rsp_err=0, rsp_timeout=0; cmd_ready high again one cycle later.
- Read op, addr 3, slave model returns 0xDEADBEEF -> exactly one read strobe; rsp_data=0xDEADBEEF; rsp_valid held for 5 cycles while rsp_ready=0 with data stable; cmd_ready stays low during that time.
- Poll op, addr 0, mask 0x8, data 0x8; status bit rises on the 3rd read -> 3 read strobes spaced POLL_GAP+1 cycles apart; rsp_data has bit 3 set; rsp_timeout=0.
- Poll with POLL_MAX=4 and a bit that never sets -> exactly 4 reads; rsp_timeout=1; rsp_data equals the last read value.
- Illegal op 11 -> no cs strobe at all; rsp_err=1 on the cycle after acceptance.
- Assert reset_n low during a poll GAP -> all outputs 0 asynchronously; no response after release; next command runs normally.
